// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
// Carries opcode/mem_ready in, every mux select and enable out; no internal latency.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic               mem_ready;
  logic               pcwrite;
  logic               pcwritecond;
  logic [1:0]         pcsource;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               irwrite;
  logic               memtoreg;
  logic               regdst;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         aluop;
  logic               xorisig;
  logic               bgezsig;
  logic               balzsig;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, pcsource, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
           xorisig, bgezsig, balzsig, illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, pcsource, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
           xorisig, bgezsig, balzsig, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath; 3-5 cycles/instr, memory states stall on mem_ready.
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes lock into TRAP with a sticky illegal flag until reset.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  multicycle_control_if.master io_ctl
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BGEZ = 6'b100111;
  localparam logic [5:0] OP_BALZ = 6'b011010;

`ifdef ILLEGAL_OP_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
    S_BEQ    = 4'd8,  S_XORIEX = 4'd9,  S_XORIWB = 4'd10, S_BGEZ   = 4'd11,
    S_BALZ   = 4'd12, S_TRAP   = 4'd13
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
    S_BEQ    = 4'd8,  S_XORIEX = 4'd9,  S_XORIWB = 4'd10, S_BGEZ   = 4'd11,
    S_BALZ   = 4'd12
  } state_t;
`endif

  typedef struct packed {
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       xorisig;
    logic       bgezsig;
    logic       balzsig;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_run;
  logic   w_fetch_done;

  // Per-state control word; computed for the next state so the outputs come straight off flops.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_REXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ, S_BGEZ, S_BALZ: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
        c.bgezsig     = (s == S_BGEZ);
        c.balzsig     = (s == S_BALZ);
        c.regwrite    = (s == S_BALZ);
      end
      S_XORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = 2'b11;
        c.xorisig = 1'b1;
      end
      S_XORIWB: begin
        c.regwrite = 1'b1;
        c.xorisig  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = io_ctl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (io_ctl.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_REXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_XORI:      w_next = S_XORIEX;
          OP_BGEZ:      w_next = S_BGEZ;
          OP_BALZ:      w_next = S_BALZ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (io_ctl.op == OP_LW)      w_next = S_MEMRD;
        else if (io_ctl.op == OP_SW) w_next = S_MEMWR;
        else                         w_next = S_FETCH;
      end
      S_MEMRD:  w_next = io_ctl.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = io_ctl.mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BEQ, S_BGEZ, S_BALZ: w_next = S_FETCH;
      S_XORIEX: w_next = S_XORIWB;
      S_XORIWB: w_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic r_illegal;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= ctrl_of(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  assign io_ctl.illegal = r_illegal & w_run;
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_of(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
    end
  end

  assign io_ctl.illegal = 1'b0;
`endif

  // Reset masks every output combinationally so an aborted store cannot leak a write.
  assign w_run        = ~i_reset;
  assign w_fetch_done = (r_state == S_FETCH) & io_ctl.mem_ready & w_run;

  assign io_ctl.pcwrite     = w_fetch_done;
  assign io_ctl.irwrite     = w_fetch_done;
  assign io_ctl.pcwritecond = r_ctrl.pcwritecond & w_run;
  assign io_ctl.pcsource    = r_ctrl.pcsource & {2{w_run}};
  assign io_ctl.iord        = r_ctrl.iord & w_run;
  assign io_ctl.memread     = r_ctrl.memread & w_run;
  assign io_ctl.memwrite    = r_ctrl.memwrite & w_run;
  assign io_ctl.memtoreg    = r_ctrl.memtoreg & w_run;
  assign io_ctl.regdst      = r_ctrl.regdst & w_run;
  assign io_ctl.regwrite    = r_ctrl.regwrite & w_run;
  assign io_ctl.alusrca     = r_ctrl.alusrca & w_run;
  assign io_ctl.alusrcb     = r_ctrl.alusrcb & {2{w_run}};
  assign io_ctl.aluop       = r_ctrl.aluop & {2{w_run}};
  assign io_ctl.xorisig     = r_ctrl.xorisig & w_run;
  assign io_ctl.bgezsig     = r_ctrl.bgezsig & w_run;
  assign io_ctl.balzsig     = r_ctrl.balzsig & w_run;
  assign io_ctl.state       = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction cycle traces are queued by the
// stimulus and popped/compared once per cycle by an independent monitor.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BGEZ = 6'b100111;
  localparam logic [5:0] OP_BALZ = 6'b011010;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       xorisig;
    logic       bgezsig;
    logic       balzsig;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;
  exp_t q[$];

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_ctl  (bus)
  );

  always #5 clk = ~clk;

  // Expected control word by state, straight from the instruction-step table.
  function automatic outs_t model_outs(input int st, input bit mr, input bit rst);
    outs_t o;
    o = '0;
    if (rst) return o;
    case (st)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.pcwrite = mr; o.irwrite = mr; end
      1:  o.alusrcb = 2'b11;
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8, 11, 12: begin
        o.alusrca = 1; o.aluop = 2'b01; o.pcwritecond = 1; o.pcsource = 2'b01;
        o.bgezsig = (st == 11); o.balzsig = (st == 12); o.regwrite = (st == 12);
      end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 2'b11; o.xorisig = 1; end
      10: begin o.regwrite = 1; o.xorisig = 1; end
      13: o.illegal = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs after the edge and queue what the DUT should show this cycle.
  task automatic cyc(input bit rst, input bit mr, input logic [5:0] opv, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = mr;
    bus.op        = opv;
    e.st = 4'(st);
    e.o  = model_outs(st, mr, rst);
    q.push_back(e);
  endtask

  task automatic trap_then_reset(input int n);
    for (int i = 0; i < n; i++) cyc(0, rbit(), rnd_op(), 13);
    cyc(1, rbit(), rnd_op(), 13);
  endtask

  // op is only meaningful in DECODE/MEMADR, so it is scrambled everywhere else.
  task automatic run_instr(input logic [5:0] opv, input int fs, input int ms);
    for (int i = 0; i < fs; i++) cyc(0, 0, rnd_op(), 0);
    cyc(0, 1, rnd_op(), 0);
    cyc(0, rbit(), opv, 1);
    case (opv)
      OP_LW: begin
        cyc(0, rbit(), opv, 2);
        for (int i = 0; i < ms; i++) cyc(0, 0, rnd_op(), 3);
        cyc(0, 1, rnd_op(), 3);
        cyc(0, rbit(), rnd_op(), 4);
      end
      OP_SW: begin
        cyc(0, rbit(), opv, 2);
        for (int i = 0; i < ms; i++) cyc(0, 0, rnd_op(), 5);
        cyc(0, 1, rnd_op(), 5);
      end
      OP_R:    begin cyc(0, rbit(), rnd_op(), 6); cyc(0, rbit(), rnd_op(), 7); end
      OP_BEQ:  cyc(0, rbit(), rnd_op(), 8);
      OP_BGEZ: cyc(0, rbit(), rnd_op(), 11);
      OP_BALZ: cyc(0, rbit(), rnd_op(), 12);
      OP_XORI: begin cyc(0, rbit(), rnd_op(), 9); cyc(0, rbit(), rnd_op(), 10); end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        trap_then_reset(10);
`endif
      end
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ ||
           o == OP_XORI || o == OP_BGEZ || o == OP_BALZ;
  endfunction

  // Monitor: every cycle with a queued expectation is checked at the falling edge.
  initial begin
    exp_t  e;
    outs_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cyc++;
        act = '{bus.pcwrite, bus.pcwritecond, bus.pcsource, bus.iord, bus.memread,
                bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.aluop, bus.xorisig, bus.bgezsig,
                bus.balzsig, bus.illegal};
        n_cmp++;
        if (bus.state !== e.st) begin
          n_bad++;
          $display("FAIL state cyc=%0d got=%0d expected=%0d", n_cyc, bus.state, e.st);
        end
        n_cmp++;
        if (act !== e.o) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d state=%0d got=%h expected=%h",
                   n_cyc, e.st, act, e.o);
        end
      end
    end
  end

  initial begin
    logic [5:0] legal[7];
    logic [5:0] opv;
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_XORI, OP_BGEZ, OP_BALZ};
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.op        = 6'h00;

    cyc(1, 1, 6'h00, 0);
    cyc(1, 1, 6'h00, 0);

    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_R, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BGEZ, 1, 0);
    run_instr(OP_BALZ, 0, 0);
    run_instr(OP_XORI, 2, 0);
    run_instr(OP_LW, 1, 2);
    run_instr(6'b111111, 0, 0);

    // Abort a stalled store: outputs drop while reset is high, then FETCH without memwrite.
    cyc(0, 1, rnd_op(), 0);
    cyc(0, 1, OP_SW, 1);
    cyc(0, 1, OP_SW, 2);
    cyc(0, 0, rnd_op(), 5);
    cyc(1, 0, rnd_op(), 5);
    cyc(0, 0, rnd_op(), 0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do opv = rnd_op(); while (is_legal(opv));
      end else begin
        opv = legal[$urandom_range(0, 6)];
      end
      run_instr(opv, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
